// File: rtl/shift_serdes.sv
// shift_serdes: full-duplex shift-register serialiser/deserialiser with start/busy/done handshake.
// Optional even-parity bit appended to each frame when SERDES_PARITY_EN is defined.
module shift_serdes #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] d,
    input  logic         sin,
    output logic         sout,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic         perr
);
    localparam int CW = $clog2(N + 1);
`ifdef SERDES_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t         r_state;
    logic [N-1:0]   r_sr;
    logic [N-1:0]   r_q;
    logic [CW-1:0]  r_cnt;
    logic           r_done;
    logic [N-1:0]   w_sr_shift;
    logic [N-1:0]   w_rx_word;
    logic           w_sr_bit;
    logic           w_last;
    logic           w_shift_en;

    assign w_sr_shift = MSB_FIRST ? {r_sr[N-2:0], sin} : {sin, r_sr[N-1:1]};
    assign w_sr_bit   = MSB_FIRST ? r_sr[N-1] : r_sr[0];
    assign w_last     = (r_cnt == '0);
    assign busy       = (r_state == SHIFT);
    assign done       = r_done;
    assign q          = r_q;

`ifdef SERDES_PARITY_EN
    logic r_par_tx;
    logic r_perr;

    // The final SHIFT cycle carries the parity bit, so the data register is frozen then.
    assign w_shift_en = !w_last;
    assign w_rx_word  = r_sr;
    assign sout       = busy & (w_last ? r_par_tx : w_sr_bit);
    assign perr       = r_perr;

    // Latch transmit parity on accept; check received parity against the word on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_tx <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            if (!busy && start)
                r_par_tx <= ^d;
            if (busy && w_last)
                r_perr <= sin ^ (^r_sr);
        end
    end
`else
    // Last data bit is sampled on the completing edge, so q takes the shifted value.
    assign w_shift_en = 1'b1;
    assign w_rx_word  = w_sr_shift;
    assign sout       = busy & w_sr_bit;
    assign perr       = 1'b0;
`endif

    // Frame FSM: accept in IDLE, shift FL cycles, publish q with a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (start) begin
                    r_sr    <= d;
                    r_cnt   <= CW'(FL - 1);
                    r_state <= SHIFT;
                end
            end else begin
                if (w_shift_en)
                    r_sr <= w_sr_shift;
                if (w_last) begin
                    r_state <= IDLE;
                    r_q     <= w_rx_word;
                    r_done  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_serdes.sv
// tb_shift_serdes: scoreboard bench driving an MSB-first and an LSB-first shift_serdes in lockstep.
module tb_shift_serdes;
`ifdef SERDES_PARITY_EN
    localparam int FL  = 9;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = 8;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, sin_m, sin_l;
    logic [7:0] d;
    logic       sout_m, busy_m, done_m, perr_m;
    logic       sout_l, busy_l, done_l, perr_l;
    logic [7:0] q_m, q_l;
    int         total = 0;
    int         bad = 0;
    logic [7:0] sb_q[$];
    logic       sb_p[$];

    shift_serdes #(.N(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .start(start), .d(d), .sin(sin_m),
        .sout(sout_m), .busy(busy_m), .done(done_m), .q(q_m), .perr(perr_m)
    );

    shift_serdes #(.N(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .start(start), .d(d), .sin(sin_l),
        .sout(sout_l), .busy(busy_l), .done(done_l), .q(q_l), .perr(perr_l)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        total++;
        if ({busy_m, busy_l, sout_m, sout_l, done_m, done_l} !== 6'b0) begin
            bad++;
            $display("FAIL %s idle: busy=%b%b sout=%b%b done=%b%b want all 0", tag, busy_m, busy_l, sout_m, sout_l, done_m, done_l);
        end
    endtask

    task automatic do_frame(input logic [7:0] tx, input logic [7:0] rx, input logic rxpar, input bit perturb, input bit hold);
        logic [7:0] eq;
        logic       ep, es_m, es_l;
        start = 1'b1;
        d     = tx;
        sb_q.push_back(rx);
        sb_p.push_back(PAR ? (rxpar ^ (^rx)) : 1'b0);
        step();
        for (int k = 1; k <= FL; k++) begin
            es_m = (k <= 8) ? tx[8-k] : ^tx;
            es_l = (k <= 8) ? tx[k-1] : ^tx;
            total++;
            if (busy_m !== 1'b1 || busy_l !== 1'b1) begin
                bad++;
                $display("FAIL busy cycle %0d tx=%h: got m=%b l=%b want 1", k, tx, busy_m, busy_l);
            end
            total++;
            if (sout_m !== es_m) begin
                bad++;
                $display("FAIL sout_msb cycle %0d tx=%h: got %b want %b", k, tx, sout_m, es_m);
            end
            total++;
            if (sout_l !== es_l) begin
                bad++;
                $display("FAIL sout_lsb cycle %0d tx=%h: got %b want %b", k, tx, sout_l, es_l);
            end
            total++;
            if (done_m !== 1'b0 || done_l !== 1'b0) begin
                bad++;
                $display("FAIL early_done cycle %0d: got m=%b l=%b want 0", k, done_m, done_l);
            end
            sin_m = (k <= 8) ? rx[8-k] : rxpar;
            sin_l = (k <= 8) ? rx[k-1] : rxpar;
            start = hold || (perturb && k == 4);
            d     = (perturb && k == 4) ? 8'hFF : (hold ? tx : 8'($urandom));
            step();
        end
        total++;
        if (busy_m !== 1'b0 || busy_l !== 1'b0 || done_m !== 1'b1 || done_l !== 1'b1) begin
            bad++;
            $display("FAIL done_cycle tx=%h: busy=%b%b done=%b%b want busy 00 done 11", tx, busy_m, busy_l, done_m, done_l);
        end
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: done with no expected frame");
        end else begin
            eq = sb_q.pop_front();
            ep = sb_p.pop_front();
            if (q_m !== eq || q_l !== eq) begin
                bad++;
                $display("FAIL q rx=%h: got m=%h l=%h want %h", rx, q_m, q_l, eq);
            end
            total++;
            if (perr_m !== ep || perr_l !== ep) begin
                bad++;
                $display("FAIL perr rx=%h par=%b: got m=%b l=%b want %b", rx, rxpar, perr_m, perr_l, ep);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            d     = 8'($urandom);
            sin_m = 1'($urandom);
            sin_l = 1'($urandom);
            step();
            check_idle("reset");
            total++;
            if (q_m !== 8'h00 || q_l !== 8'h00 || perr_m !== 1'b0 || perr_l !== 1'b0) begin
                bad++;
                $display("FAIL reset_q: q=%h/%h perr=%b%b want 00 and 0", q_m, q_l, perr_m, perr_l);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        check_idle("post_reset");
    endtask

    task automatic test_basic();
        do_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
        step();
        check_idle("basic_after");
    endtask

    task automatic test_ignore_start();
        do_frame(8'hA5, 8'hC3, 1'b1, 1'b1, 1'b0);
        step();
        check_idle("ignore_after");
    endtask

    task automatic test_back_to_back();
        do_frame(8'h81, 8'h5A, 1'b0, 1'b0, 1'b1);
        do_frame(8'h81, 8'hA6, 1'b1, 1'b0, 1'b1);
        do_frame(8'h81, 8'h11, 1'b0, 1'b0, 1'b0);
        step();
        check_idle("b2b_after");
    endtask

    task automatic test_abort();
        start = 1'b1;
        d     = 8'h5A;
        sb_q.push_back(8'hFF);
        sb_p.push_back(1'b0);
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            sin_m = 1'b1;
            sin_l = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("abort");
        total++;
        if (q_m !== 8'h00 || q_l !== 8'h00 || perr_m !== 1'b0 || perr_l !== 1'b0) begin
            bad++;
            $display("FAIL abort_q: q=%h/%h perr=%b%b want 00 and 0", q_m, q_l, perr_m, perr_l);
        end
        void'(sb_q.pop_back());
        void'(sb_p.pop_back());
        for (int i = 0; i < FL + 2; i++) begin
            step();
            check_idle("abort_after");
        end
        do_frame(8'h3C, 8'h96, 1'b0, 1'b0, 1'b0);
        step();
        check_idle("abort_recover");
    endtask

    task automatic test_lsb_first();
        do_frame(8'h01, 8'h80, 1'b1, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_parity();
        do_frame(8'h07, 8'h01, 1'b0, 1'b0, 1'b0);
        do_frame(8'h07, 8'h03, 1'b0, 1'b0, 1'b0);
        do_frame(8'hE2, 8'h7F, 1'b1, 1'b0, 1'b0);
        step();
        check_idle("parity_after");
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        d     = 8'h00;
        sin_m = 1'b0;
        sin_l = 1'b0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        test_lsb_first();
        test_parity();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
